adc_readout_ctrl: RTL and testbench

ADC_READOUT_CTRL -- requirements
Module: adc_readout_ctrl

---
 rtl/adc_readout_ctrl.sv | 143 ++++++++++++++
 tb/tb_adc_readout_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/adc_readout_ctrl.sv
// Readout controller for an 8-channel serial ADC: it resets the ADC interface, shifts one
// conversion in from each channel, then serializes the frame on DataOut/ClkOut.
module adc_readout_ctrl #(
    parameter int ADC_BITS = 12,
    parameter int RST_CYC  = 2
) (
    input  logic       OSC_in,
    input  logic       pushbutton,
    input  logic       start,
    input  logic [7:0] ADSout,
    output logic       ADRst,
    output logic       ADClk,
    output logic       DataOut,
    output logic       ClkOut,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] dbg_state
);

    localparam int BIT_W = $clog2(ADC_BITS + 1);
    localparam int UNL_W = $clog2(8 * ADC_BITS + 1);
    localparam int RST_W = $clog2(RST_CYC + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ADC_BITS - 1);
    localparam logic [UNL_W-1:0] LAST_UNL = UNL_W'(8 * ADC_BITS - 1);
    localparam logic [RST_W-1:0] LAST_RST = RST_W'(RST_CYC - 1);

    typedef enum logic [2:0] {IDLE, ADRST, SHIFT, UNLOAD, DONE} state_t;
    typedef logic [7:0][ADC_BITS-1:0] bank_t;

    state_t           state;
    bank_t            sr;
    bank_t            sr_cap;
    logic             phase;
    logic [RST_W-1:0] rst_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [UNL_W-1:0] unl_cnt;

    assign dbg_state = state;

    always_comb begin
        sr_cap = sr;
        for (int ch = 0; ch < 8; ch++) begin
            sr_cap[ch] = {sr[ch][ADC_BITS-2:0], ADSout[ch]};
        end
    end

    // During unload the eight registers act as one long chain: channel 1 MSB leaves
    // first and each channel's MSB feeds the LSB of the channel before it.
    function automatic bank_t chain(input bank_t s);
        bank_t r;
        for (int ch = 0; ch < 7; ch++) begin
            r[ch] = {s[ch][ADC_BITS-2:0], s[ch+1][ADC_BITS-1]};
        end
        r[7] = {s[7][ADC_BITS-2:0], 1'b0};
        return r;
    endfunction

    always_ff @(posedge OSC_in) begin
        if (pushbutton) begin
            state      <= IDLE;
            sr         <= '0;
            phase      <= 1'b0;
            rst_cnt    <= '0;
            bit_cnt    <= '0;
            unl_cnt    <= '0;
            ADRst      <= 1'b0;
            ADClk      <= 1'b0;
            DataOut    <= 1'b0;
            ClkOut     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ADRST;
                        ADRst   <= 1'b1;
                        busy    <= 1'b1;
                        rst_cnt <= '0;
                    end
                end
                ADRST: begin
                    if (rst_cnt == LAST_RST) begin
                        state   <= SHIFT;
                        ADRst   <= 1'b0;
                        ADClk   <= 1'b1;
                        phase   <= 1'b0;
                        bit_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!phase) begin
                        ADClk <= 1'b0;
                        phase <= 1'b1;
                    end else if (bit_cnt == LAST_BIT) begin
                        // Last capture: the first frame bit comes straight from the fresh word.
                        state   <= UNLOAD;
                        DataOut <= sr_cap[0][ADC_BITS-1];
                        sr      <= chain(sr_cap);
                        unl_cnt <= '0;
                        ClkOut  <= 1'b0;
                        phase   <= 1'b0;
                    end else begin
                        sr      <= sr_cap;
                        bit_cnt <= bit_cnt + 1'b1;
                        ADClk   <= 1'b1;
                        phase   <= 1'b0;
                    end
                end
                UNLOAD: begin
                    if (!phase) begin
                        ClkOut <= 1'b1;
                        phase  <= 1'b1;
                    end else if (unl_cnt == LAST_UNL) begin
                        state      <= DONE;
                        DataOut    <= 1'b0;
                        ClkOut     <= 1'b0;
                        phase      <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        unl_cnt <= unl_cnt + 1'b1;
                        DataOut <= sr[0][ADC_BITS-1];
                        sr      <= chain(sr);
                        ClkOut  <= 1'b0;
                        phase   <= 1'b0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_readout_ctrl.sv
// Bench for adc_readout_ctrl: an ADC model serves per-channel words, and a bit queue
// holds the frame expected on DataOut at each ClkOut rise.
module tb_adc_readout_ctrl;

    logic       OSC_in = 1'b0;
    logic       pushbutton, start;
    logic [7:0] ADSout;
    logic       ADRst, ADClk, DataOut, ClkOut, busy, frame_done;
    logic [2:0] dbg_state;

    adc_readout_ctrl #(.ADC_BITS(12), .RST_CYC(2)) dut (
        .OSC_in(OSC_in), .pushbutton(pushbutton), .start(start), .ADSout(ADSout),
        .ADRst(ADRst), .ADClk(ADClk), .DataOut(DataOut), .ClkOut(ClkOut),
        .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    always #5 OSC_in = ~OSC_in;

    typedef struct {
        logic [7:0][11:0] w;
        int               exp_ones;
    } vec_t;

    vec_t             vecs [4];
    logic [7:0][11:0] words;
    logic [0:0]       exp_q [$];
    int n_checks = 0, n_err = 0;
    int cyc = 0, bit_idx = 0;
    int adrst_cyc, adclk_rises, clk_rises, ones, fd_count, fd_cyc, rise_cyc;
    logic prev_adclk = 0, prev_clkout = 0, prev_adrst = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_counts();
        adrst_cyc = 0; adclk_rises = 0; clk_rises = 0; ones = 0; fd_count = 0;
    endtask

    task automatic push_frame(input logic [7:0][11:0] w);
        for (int ch = 0; ch < 8; ch++)
            for (int b = 11; b >= 0; b--) exp_q.push_back(w[ch][b]);
    endtask

    // One clock: sample outputs 1 ns after the edge, run the ADC model and the scoreboard.
    task automatic tick();
        logic [0:0] e;
        @(posedge OSC_in);
        #1;
        cyc++;
        if (ADRst) begin
            bit_idx = 0;
            adrst_cyc++;
            if (!prev_adrst) rise_cyc = cyc;
        end
        if (prev_adclk && !ADClk && bit_idx < 12) begin
            for (int ch = 0; ch < 8; ch++) ADSout[ch] = words[ch][11 - bit_idx];
            bit_idx++;
        end else begin
            ADSout = 8'($urandom_range(0, 255));
        end
        if (ADClk && !prev_adclk) adclk_rises++;
        if (ClkOut && !prev_clkout) begin
            clk_rises++;
            if (DataOut === 1'b1) ones++;
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("dataout_bit", 32'(DataOut), 32'(e));
            end
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
        prev_adclk = ADClk; prev_clkout = ClkOut; prev_adrst = ADRst;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"}, {26'd0, ADRst, ADClk, DataOut, ClkOut, busy, frame_done}, 0);
        check({name, "_state"}, 32'(dbg_state), 0);
    endtask

    task automatic run_frame(input vec_t v, input bit inject);
        int cap;
        words = v.w;
        push_frame(v.w);
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        cap = cyc;
        check("adrst_on_capture", 32'(ADRst), 1);
        for (int i = 0; i < 400 && fd_count == 0; i++) begin
            start = inject && (clk_rises == 10);
            tick();
        end
        start = 1'b0;
        if (fd_count == 0) begin
            check("frame_timeout", 0, 1);
            return;
        end
        check("frame_len", 32'(fd_cyc - cap), 218);
        check("busy_at_done", 32'(busy), 1);
        check("adrst_cycles", 32'(adrst_cyc), 2);
        check("adclk_pulses", 32'(adclk_rises), 12);
        check("clkout_pulses", 32'(clk_rises), 96);
        check("ones_count", 32'(ones), 32'(v.exp_ones));
        tick();
        check("frame_done_width", 32'(frame_done), 0);
        check("busy_after_done", 32'(busy), 0);
        for (int i = 0; i < 20; i++) tick();
        check("single_frame_done", 32'(fd_count), 1);
        check("idle_after_frame", 32'(busy), 0);
        check("queue_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int fd1;
        vecs[0].w = '0; vecs[0].w[0] = 12'hA5C; vecs[0].exp_ones = 6;
        vecs[1].w = '1;                         vecs[1].exp_ones = 96;
        vecs[2].w = '0; vecs[2].w[7] = 12'hFFF; vecs[2].exp_ones = 12;
        vecs[3].w = '0; vecs[3].w[3] = 12'h801; vecs[3].w[1] = 12'h3F0; vecs[3].exp_ones = 8;
        words = '0;
        ADSout = '0;
        pushbutton = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all_zero("reset_hold");
        end
        pushbutton = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_all_zero("idle_wait");

        for (int i = 0; i < 4; i++) run_frame(vecs[i], 1'b0);

        // start pulsed during UNLOAD must be dropped
        run_frame(vecs[3], 1'b1);

        // reset at bit 40 of UNLOAD, then a clean ch8 frame
        words = vecs[0].w;
        push_frame(vecs[0].w);
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 300 && clk_rises < 40; i++) tick();
        check("reached_bit40", 32'(clk_rises), 40);
        pushbutton = 1'b1;
        tick();
        check_all_zero("mid_unload_reset");
        pushbutton = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) tick();
        check_all_zero("post_reset_idle");
        run_frame(vecs[2], 1'b0);

        // start tied high: back-to-back frames with one IDLE cycle between
        words = vecs[3].w;
        push_frame(vecs[3].w);
        push_frame(vecs[3].w);
        clear_counts();
        fd1 = -1;
        start = 1'b1;
        for (int i = 0; i < 600 && fd_count < 2; i++) begin
            tick();
            if (fd_count == 1 && fd1 < 0) fd1 = fd_cyc;
            if (fd1 >= 0 && rise_cyc > fd1 && fd_count == 1) begin
                check("b2b_gap", 32'(rise_cyc - fd1), 2);
                fd1 = 1 << 30;
            end
        end
        start = 1'b0;
        check("b2b_frames", 32'(fd_count), 2);
        for (int i = 0; i < 10; i++) tick();
        check("b2b_stop", 32'(busy), 0);
        check("b2b_queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
